keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the four-digit seven-segment display driver: where the display cycles anodes outward, this block scans a 4x4 hex keypad matrix inward.
- Drives one row low at a time, reads the four columns, debounces, and decodes the pressed key to a hex nibble.
- Accepted keys shift into a 16-bit entry register; that register feeds the display's num_pi, so the display shows the last four keys entered.
- Scan rate comes from the same slow clock-enable tick the display uses.

Parameters:
- DEBOUNCE_TICKS, 4: number of consecutive matching scan-tick samples needed to accept a press, and consecutive all-high samples needed to accept a release. Legal range is 1..15.

Ports:
- clk_pi  in  1  system clock
- rst_n_pi  in  1  asynchronous active-low reset
- clk_en_pi  in  1  scan tick, one clk_pi cycle wide (shared with the display)
- col_pi  in  4  keypad columns, active low, externally pulled up; asynchronous input
- row_po  out  4  row drive, active-low one-hot
- key_po  out  4  hex code of the last accepted key
- key_valid_po  out  1  one-cycle pulse when a new key is accepted
- key_held_po  out  1  high while an accepted key is still down
- num_po  out  16  entry register; the newest key is in [3:0]

Behaviour:
- Reset: all outputs and state clear asynchronously on rst_n_pi low.
  - row_po = 4'b1110, key_po = 0, key_valid_po = 0, key_held_po = 0, num_po = 0.
  - State = SCAN, counters = 0, synchronizer flops = 4'b1111.
  - Reset mid-debounce or mid-hold discards the candidate and emits no pulse.
- Synchronizer: col_pi passes through a 2-flop synchronizer clocked every clk_pi, regardless of clk_en_pi. The synchronized value is "cols".
- Sampling: all state and row logic advances only on clk_pi edges where clk_en_pi = 1. With clk_en_pi low, everything except the synchronizer holds.
- Row index r (0..3): row_po = ~(1 << r). A row is driven for at least one full tick before its cols are sampled.
- Keymap (row, col index 0..3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- States:
  - SCAN, on tick:
    - If cols has exactly one low bit: capture candidate (r, cols), set cnt = 1, hold r.
    - If DEBOUNCE_TICKS = 1: accept immediately.
    - Otherwise go to DEBOUNCE.
    - If cols = 4'b1111, or more than one bit is low (ghost/multi-press): r = r + 1 mod 4, stay in SCAN.
  - DEBOUNCE, on tick:
    - If cols equals the captured pattern: cnt = cnt + 1. When cnt reaches DEBOUNCE_TICKS, accept.
    - If cols differs: discard the candidate, r = r + 1 mod 4, go to SCAN with no output change.
  - Accept, in the same tick edge:
    - key_po = decoded code.
    - num_po = {num_po[11:0], code}.
    - key_valid_po = 1 for exactly that one following clk_pi cycle (registered; cleared on the next edge).
    - key_held_po = 1, cnt = 0, go to HELD.
  - HELD, on tick (row stays fixed):
    - If cols = 4'b1111: cnt = cnt + 1.
    - Else: cnt = 0.
    - When cnt reaches DEBOUNCE_TICKS: key_held_po = 0, r = r + 1 mod 4, go to SCAN.
    - Another key pressed on a different row while held is not seen. Another key on the same row keeps the hold active and produces no new pulse.
- Latency: from stable press (assuming the row is being driven) to key_valid_po = DEBOUNCE_TICKS ticks + ≤2 clk synchronizer delay + 1 clk.
- Entry register: holding a key never auto-repeats. num_po wraps by shifting, so the oldest nibble is lost.

Decomposition:
- Shared package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD}
  - ROW_IDLE = 4'b1110
  - COLS_NONE = 4'b1111
- One combinational sub-module, keypad_keymap: (row index, one-hot-low cols) -> 4-bit code, plus a "single" flag indicating exactly one low column.

Test Plan:
- Reset, then 8 ticks with no key -> row_po cycles 1110, 1101, 1011, 0111, 1110...; key_valid_po stays 0; num_po = 16'h0000.
- DEBOUNCE_TICKS = 4; hold col 2 low only while row 1 is driven, stable -> one key_valid_po pulse, key_po = 4'h6, num_po = 16'h0006, key_held_po = 1 until 4 release ticks pass.
- Keys 1, 2, 3, 4 pressed and released in sequence -> four pulses total, num_po = 16'h1234. Then press 5 -> num_po = 16'h2345.
- Bounce: candidate on r0/c0 with cols toggling every second tick for 10 ticks -> no pulse, row resumes rotating. Then stable for 4 ticks -> key_po = 4'h1.
- Cols 4'b1001 on r2 (two keys) -> no capture, row advances, no pulse. Also: clk_en_pi held low 20 clk mid-DEBOUNCE with key stable -> state frozen, then accept after the remaining ticks.
- Assert rst_n_pi during DEBOUNCE (cnt = 2) and during HELD -> outputs return to reset values immediately, with no pulse before or after reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, row/column constants and row-drive helper for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  localparam logic [3:0] ROW_IDLE  = 4'b1110;
  localparam logic [3:0] COLS_NONE = 4'b1111;

  function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
    return ~(4'b0001 << row_idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix pins and decoded key outputs of the scanner
interface keypad_scanner_if;
  logic [3:0]  col_pi;
  logic [3:0]  row_po;
  logic [3:0]  key_po;
  logic        key_valid_po;
  logic        key_held_po;
  logic [15:0] num_po;

  modport master (
    output col_pi,
    input  row_po, key_po, key_valid_po, key_held_po, num_po
  );

  modport slave (
    input  col_pi,
    output row_po, key_po, key_valid_po, key_held_po, num_po
  );
endinterface

// File: rtl/keypad_keymap.sv
// rtl/keypad_keymap.sv - maps (row index, active-low columns) to a hex key code; flags a single low column
module keypad_keymap (
  input  logic [1:0] row_idx_pi,
  input  logic [3:0] cols_pi,
  output logic [3:0] code_po,
  output logic       single_po
);

  logic [1:0] col_idx;

  always_comb begin
    single_po = 1'b1;
    col_idx   = 2'd0;
    case (cols_pi)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: single_po = 1'b0;
    endcase
  end

  always_comb begin
    code_po = 4'h0;
    case ({row_idx_pi, col_idx})
      4'h0: code_po = 4'h1;
      4'h1: code_po = 4'h2;
      4'h2: code_po = 4'h3;
      4'h3: code_po = 4'hA;
      4'h4: code_po = 4'h4;
      4'h5: code_po = 4'h5;
      4'h6: code_po = 4'h6;
      4'h7: code_po = 4'hB;
      4'h8: code_po = 4'h7;
      4'h9: code_po = 4'h8;
      4'hA: code_po = 4'h9;
      4'hB: code_po = 4'hC;
      4'hC: code_po = 4'h0;
      4'hD: code_po = 4'hF;
      4'hE: code_po = 4'hE;
      4'hF: code_po = 4'hD;
      default: code_po = 4'h0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounce, hold tracking and a 4-nibble entry register
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk_pi,
  input  logic rst_n_pi,
  input  logic clk_en_pi,
  keypad_scanner_if.slave kp
);

  localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

  state_e      state_q, state_d;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  key_q, key_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic [15:0] num_q, num_d;

  logic [3:0]  code;
  logic        single;
  logic        accept;

  keypad_keymap u_keymap (
    .row_idx_pi (idx_q),
    .cols_pi    (sync2_q),
    .code_po    (code),
    .single_po  (single)
  );

  always_comb begin
    state_d = state_q;
    sync1_d = kp.col_pi;
    sync2_d = sync1_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    num_d   = num_q;
    accept  = 1'b0;

    if (clk_en_pi) begin
      case (state_q)
        SCAN: begin
          if (single) begin
            cand_d = sync2_q;
            if (DEBOUNCE_TICKS == 1) begin
              accept = 1'b1;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (sync2_q == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DT) accept = 1'b1;
          end else begin
            cnt_d   = 4'd0;
            idx_d   = idx_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Row stays parked on the held key until it has been released for DT ticks.
          if (sync2_q == COLS_NONE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DT) begin
              cnt_d   = 4'd0;
              held_d  = 1'b0;
              idx_d   = idx_q + 2'd1;
              state_d = SCAN;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = SCAN;
        end
      endcase
    end

    if (accept) begin
      key_d   = code;
      num_d   = {num_q[11:0], code};
      valid_d = 1'b1;
      held_d  = 1'b1;
      cnt_d   = 4'd0;
      state_d = HELD;
    end

    row_d = row_drive(idx_d);
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q <= SCAN;
      sync1_q <= COLS_NONE;
      sync2_q <= COLS_NONE;
      idx_q   <= 2'd0;
      row_q   <= ROW_IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= COLS_NONE;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      num_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      num_q   <= num_d;
    end
  end

  assign kp.row_po       = row_q;
  assign kp.key_po       = key_q;
  assign kp.key_valid_po = valid_q;
  assign kp.key_held_po  = held_q;
  assign kp.num_po       = num_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed scenario bench for keypad_scanner with a behavioural key matrix
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        p_on = 1'b0;
  logic [1:0]  p_row = 2'd0;
  logic [1:0]  p_col = 2'd0;
  logic        force_en = 1'b0;
  logic [3:0]  force_cols = 4'hF;
  logic [15:0] exp_num = 16'h0000;
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(.DEBOUNCE_TICKS(4)) dut (
    .clk_pi    (clk),
    .rst_n_pi  (rst_n),
    .clk_en_pi (clk_en),
    .kp        (kp)
  );

  // Pressed switch shorts its column to the row line only while that row is driven low.
  assign kp.col_pi = force_en ? force_cols :
                     (p_on && kp.row_po[p_row] == 1'b0) ? ~(4'b0001 << p_col) : 4'hF;

  always #5 clk = ~clk;

  always @(negedge clk) if (kp.key_valid_po === 1'b1) pulse_cnt++;

  task automatic tick();
    repeat (3) @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic wait_row(input logic [1:0] r);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << r);
    n = 0;
    while (kp.row_po !== want && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (kp.row_po !== want) begin
      errors++;
      $display("FAIL wait_row: row_po=%b expected %b", kp.row_po, want);
    end
  endtask

  task automatic press_key(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code);
    int base;
    wait_row(r);
    p_row = r; p_col = c; p_on = 1'b1;
    base = pulse_cnt;
    repeat (3) tick();
    checks++;
    if (pulse_cnt !== base) begin
      errors++; $display("FAIL early_pulse: pulses=%0d expected %0d", pulse_cnt, base);
    end
    tick();
    exp_num = {exp_num[11:0], code};
    checks++;
    if ({kp.key_valid_po, kp.key_held_po, kp.key_po, kp.num_po} !== {1'b1, 1'b1, code, exp_num}) begin
      errors++;
      $display("FAIL accept: valid=%b held=%b key=%h num=%h expected 1 1 %h %h",
               kp.key_valid_po, kp.key_held_po, kp.key_po, kp.num_po, code, exp_num);
    end
    @(negedge clk);
    checks++;
    if (kp.key_valid_po !== 1'b0) begin
      errors++; $display("FAIL pulse_width: valid=%b expected 0", kp.key_valid_po);
    end
    repeat (5) tick();
    checks++;
    if (kp.key_held_po !== 1'b1 || pulse_cnt !== base + 1 || kp.row_po !== ~(4'b0001 << r)) begin
      errors++;
      $display("FAIL hold: held=%b pulses=%0d row=%b expected 1 %0d %b",
               kp.key_held_po, pulse_cnt, kp.row_po, base + 1, ~(4'b0001 << r));
    end
    p_on = 1'b0;
    repeat (3) tick();
    checks++;
    if (kp.key_held_po !== 1'b1) begin
      errors++; $display("FAIL release_early: held=%b expected 1", kp.key_held_po);
    end
    tick();
    checks++;
    if (kp.key_held_po !== 1'b0 || kp.row_po !== ~(4'b0001 << (r + 2'd1))) begin
      errors++;
      $display("FAIL release: held=%b row=%b expected 0 %b", kp.key_held_po, kp.row_po,
               ~(4'b0001 << (r + 2'd1)));
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({kp.row_po, kp.key_po, kp.key_valid_po, kp.key_held_po, kp.num_po} !== {4'b1110, 4'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state: row=%b key=%h valid=%b held=%b num=%h expected 1110 0 0 0 0000",
               kp.row_po, kp.key_po, kp.key_valid_po, kp.key_held_po, kp.num_po);
    end
    rst_n = 1'b1;
    exp_row = 4'b1110;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_row = {exp_row[2:0], exp_row[3]};
      checks++;
      if (kp.row_po !== exp_row) begin
        errors++; $display("FAIL idle_row%0d: row=%b expected %b", k, kp.row_po, exp_row);
      end
    end
    checks++;
    if (pulse_cnt !== 0 || kp.num_po !== 16'h0000) begin
      errors++; $display("FAIL idle_quiet: pulses=%0d num=%h expected 0 0000", pulse_cnt, kp.num_po);
    end
  endtask

  task automatic test_single_key();
    press_key(2'd1, 2'd2, 4'h6);
  endtask

  task automatic test_sequence();
    int base;
    base = pulse_cnt;
    press_key(2'd0, 2'd0, 4'h1);
    press_key(2'd0, 2'd1, 4'h2);
    press_key(2'd0, 2'd2, 4'h3);
    press_key(2'd1, 2'd0, 4'h4);
    checks++;
    if (kp.num_po !== 16'h1234 || pulse_cnt !== base + 4) begin
      errors++; $display("FAIL seq_1234: num=%h pulses=%0d expected 1234 %0d", kp.num_po, pulse_cnt, base + 4);
    end
    press_key(2'd1, 2'd1, 4'h5);
    checks++;
    if (kp.num_po !== 16'h2345) begin
      errors++; $display("FAIL seq_wrap: num=%h expected 2345", kp.num_po);
    end
  endtask

  task automatic test_bounce();
    int base;
    logic [9:0] pat;
    pat = 10'b1100110011;
    wait_row(2'd0);
    p_row = 2'd0; p_col = 2'd0;
    base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      p_on = pat[i];
      tick();
    end
    checks++;
    if (pulse_cnt !== base || kp.row_po !== 4'b1110) begin
      errors++; $display("FAIL bounce: pulses=%0d row=%b expected %0d 1110", pulse_cnt, kp.row_po, base);
    end
    p_on = 1'b1;
    repeat (3) tick();
    checks++;
    if (pulse_cnt !== base) begin
      errors++; $display("FAIL bounce_early: pulses=%0d expected %0d", pulse_cnt, base);
    end
    tick();
    exp_num = {exp_num[11:0], 4'h1};
    checks++;
    if ({kp.key_valid_po, kp.key_po, kp.num_po} !== {1'b1, 4'h1, 16'h3451}) begin
      errors++;
      $display("FAIL bounce_accept: valid=%b key=%h num=%h expected 1 1 3451", kp.key_valid_po, kp.key_po, kp.num_po);
    end
    p_on = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_ghost();
    int base;
    wait_row(2'd2);
    base = pulse_cnt;
    force_cols = 4'b1001;
    force_en = 1'b1;
    tick();
    force_en = 1'b0;
    checks++;
    if (kp.row_po !== 4'b0111 || pulse_cnt !== base) begin
      errors++; $display("FAIL ghost: row=%b pulses=%0d expected 0111 %0d", kp.row_po, pulse_cnt, base);
    end
  endtask

  task automatic test_freeze();
    int base;
    wait_row(2'd2);
    p_row = 2'd2; p_col = 2'd1; p_on = 1'b1;
    base = pulse_cnt;
    repeat (2) tick();
    repeat (20) @(negedge clk);
    checks++;
    if (kp.row_po !== 4'b1011 || kp.key_held_po !== 1'b0 || pulse_cnt !== base) begin
      errors++;
      $display("FAIL freeze: row=%b held=%b pulses=%0d expected 1011 0 %0d", kp.row_po, kp.key_held_po, pulse_cnt, base);
    end
    tick();
    checks++;
    if (pulse_cnt !== base) begin
      errors++; $display("FAIL freeze_early: pulses=%0d expected %0d", pulse_cnt, base);
    end
    tick();
    checks++;
    if ({kp.key_valid_po, kp.key_po, kp.num_po} !== {1'b1, 4'h8, 16'h4518}) begin
      errors++;
      $display("FAIL freeze_accept: valid=%b key=%h num=%h expected 1 8 4518", kp.key_valid_po, kp.key_po, kp.num_po);
    end
    p_on = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int base;
    wait_row(2'd3);
    p_row = 2'd3; p_col = 2'd1; p_on = 1'b1;
    base = pulse_cnt;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({kp.row_po, kp.key_po, kp.key_valid_po, kp.key_held_po, kp.num_po} !== {4'b1110, 4'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rst_debounce: row=%b key=%h valid=%b held=%b num=%h expected 1110 0 0 0 0000",
               kp.row_po, kp.key_po, kp.key_valid_po, kp.key_held_po, kp.num_po);
    end
    p_on = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (pulse_cnt !== base) begin
      errors++; $display("FAIL rst_debounce_pulse: pulses=%0d expected %0d", pulse_cnt, base);
    end
    wait_row(2'd0);
    p_row = 2'd0; p_col = 2'd3; p_on = 1'b1;
    repeat (4) tick();
    checks++;
    if ({kp.key_held_po, kp.key_po, kp.num_po} !== {1'b1, 4'hA, 16'h000A}) begin
      errors++;
      $display("FAIL pre_rst_hold: held=%b key=%h num=%h expected 1 a 000a", kp.key_held_po, kp.key_po, kp.num_po);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({kp.row_po, kp.key_po, kp.key_valid_po, kp.key_held_po, kp.num_po} !== {4'b1110, 4'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rst_held: row=%b key=%h valid=%b held=%b num=%h expected 1110 0 0 0 0000",
               kp.row_po, kp.key_po, kp.key_valid_po, kp.key_held_po, kp.num_po);
    end
    p_on = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (pulse_cnt !== base + 1 || kp.key_held_po !== 1'b0) begin
      errors++;
      $display("FAIL rst_held_after: pulses=%0d held=%b expected %0d 0", pulse_cnt, kp.key_held_po, base + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_ghost();
    test_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
